// File: rtl/sub_pkg.sv
// Shared types for the digit-serial subtractor.
// FSM state encoding used by the top level.
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } sub_state_t;

endpackage

// File: rtl/subtractor_digit.sv
// One digit of x - y - bin.
// Combinational; the top level muxes digits into it.
module subtractor_digit #(
   parameter int DIGIT_WIDTH = 4
) (
   input  logic [DIGIT_WIDTH-1:0] x,
   input  logic [DIGIT_WIDTH-1:0] y,
   input  logic                   bin,
   output logic [DIGIT_WIDTH-1:0] diff,
   output logic                   bout
);

   logic [DIGIT_WIDTH:0] r;

   // Extra top bit goes to 1 whenever the digit result is negative.
   assign r = {1'b0, x} - {1'b0, y}
            - {{DIGIT_WIDTH{1'b0}}, bin};
   assign diff = r[DIGIT_WIDTH-1:0];
   assign bout = r[DIGIT_WIDTH];

endmodule

// File: rtl/serial_subtractor_16bit.sv
// Digit-serial subtractor: a - b - borrow_in, one digit per clock.
// LSB digit first; result held until the next completed operation.
module serial_subtractor_16bit
   import sub_pkg::*;
#(
   parameter int BIT_WIDTH   = 16,
   parameter int DIGIT_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [BIT_WIDTH-1:0] a,
   input  logic [BIT_WIDTH-1:0] b,
   input  logic                 borrow_in,
   output logic                 busy,
   output logic                 done,
   output logic [BIT_WIDTH-1:0] difference,
   output logic                 borrow_out,
   output logic                 overflow
);

   localparam int NUM_DIGITS = BIT_WIDTH / DIGIT_WIDTH;
   localparam int CNT_W =
      (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_DIGITS - 1);
   localparam int MSB = BIT_WIDTH - 1;

   sub_state_t state;
   sub_state_t state_next;

   logic [BIT_WIDTH-1:0]   opa;
   logic [BIT_WIDTH-1:0]   opb;
   logic [BIT_WIDTH-1:0]   work;
   logic [BIT_WIDTH-1:0]   work_next;
   logic                   brw;
   logic [CNT_W-1:0]       cnt;
   logic [DIGIT_WIDTH-1:0] dx;
   logic [DIGIT_WIDTH-1:0] dy;
   logic [DIGIT_WIDTH-1:0] dd;
   logic                   dbout;
   logic                   accept;
   logic                   last;

   assign accept = start && (state == IDLE || state == DONE);
   assign last   = (state == CALC) && (cnt == LAST);
   assign busy   = (state == CALC);
   assign done   = (state == DONE);

   assign dx = opa[cnt*DIGIT_WIDTH +: DIGIT_WIDTH];
   assign dy = opb[cnt*DIGIT_WIDTH +: DIGIT_WIDTH];

   subtractor_digit #(
      .DIGIT_WIDTH(DIGIT_WIDTH)
   ) u_digit (
      .x   (dx),
      .y   (dy),
      .bin (brw),
      .diff(dd),
      .bout(dbout)
   );

   always_comb begin
      work_next = work;
      work_next[cnt*DIGIT_WIDTH +: DIGIT_WIDTH] = dd;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = CALC;
         CALC:    if (cnt == LAST) state_next = DONE;
         DONE:    state_next = start ? CALC : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs load on the edge entering DONE so they are valid with done.
   always_ff @(posedge clk) begin
      if (rst) begin
         opa        <= '0;
         opb        <= '0;
         work       <= '0;
         brw        <= 1'b0;
         cnt        <= '0;
         difference <= '0;
         borrow_out <= 1'b0;
         overflow   <= 1'b0;
      end else if (accept) begin
         opa <= a;
         opb <= b;
         brw <= borrow_in;
         cnt <= '0;
      end else if (state == CALC) begin
         work <= work_next;
         brw  <= dbout;
         cnt  <= cnt + 1'b1;
         if (last) begin
            difference <= work_next;
            borrow_out <= dbout;
            overflow   <= (opa[MSB] != opb[MSB])
                       && (work_next[MSB] != opa[MSB]);
         end
      end
   end

   a_start_known: assert property (
      @(posedge clk) !$isunknown(start));
   a_bin_known: assert property (
      @(posedge clk) !$isunknown(borrow_in));
   a_done_pulse: assert property (
      @(posedge clk) disable iff (rst)
      done |=> (!done || $past(start)));

endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// Scoreboard bench for serial_subtractor_16bit.
// Directed vectors plus a short random sweep.
module tb_serial_subtractor_16bit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        borrow_in;
   logic        busy;
   logic        done;
   logic [15:0] difference;
   logic        borrow_out;
   logic        overflow;

   typedef struct {
      logic [15:0] d;
      logic        bo;
      logic        ov;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   serial_subtractor_16bit dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .borrow_in (borrow_in),
      .busy      (busy),
      .done      (done),
      .difference(difference),
      .borrow_out(borrow_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] x,
                                  input logic [15:0] y,
                                  input logic bin,
                                  input int when);
      exp_t e;
      logic [16:0] r;
      r    = {1'b0, x} - {1'b0, y} - {16'd0, bin};
      e.d  = r[15:0];
      e.bo = r[16];
      e.ov = (x[15] != y[15]) && (r[15] != x[15]);
      e.cyc = when;
      return e;
   endfunction

   // Monitor: every done pops one expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("difference", {16'd0, difference}, {16'd0, e.d});
            check("borrow_out", {31'd0, borrow_out}, {31'd0, e.bo});
            check("overflow", {31'd0, overflow}, {31'd0, e.ov});
            check("latency", cyc, e.cyc);
            check("busy_in_done", {31'd0, busy}, 32'd0);
         end
      end
   end

   task automatic drain();
      for (int i = 0; i < 20 && q.size() != 0; i++)
         @(posedge clk);
      if (q.size() != 0) begin
         check("timeout", q.size(), 0);
         q.delete();
      end
      #1;
   endtask

   task automatic launch(input logic [15:0] x,
                         input logic [15:0] y,
                         input logic bin);
      a = x;
      b = y;
      borrow_in = bin;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      q.push_back(model(x, y, bin, cyc + 4));
   endtask

   task automatic run_op(input logic [15:0] x,
                         input logic [15:0] y,
                         input logic bin);
      launch(x, y, bin);
      drain();
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      borrow_in = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_diff", {16'd0, difference}, 32'd0);
      check("rst_bout", {31'd0, borrow_out}, 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic, wrap, overflow and cross-digit borrow cases.
      run_op(16'h1234, 16'h0034, 1'b0);
      run_op(16'h0000, 16'h0001, 1'b0);
      run_op(16'h8000, 16'h0001, 1'b0);
      run_op(16'h7FFF, 16'hFFFF, 1'b0);
      run_op(16'h1000, 16'h0000, 1'b1);
      run_op(16'h0000, 16'h0000, 1'b1);
      run_op(16'hFFFF, 16'hFFFF, 1'b1);

      // Start during CALC must be ignored.
      launch(16'h1234, 16'h0034, 1'b0);
      @(posedge clk);
      #1;
      a = 16'hFFFF;
      b = 16'h0001;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      drain();
      repeat (8) @(posedge clk);
      #1;

      // Reset in CALC cycle 3 discards the operation.
      a = 16'h0005;
      b = 16'h0003;
      borrow_in = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      check("hold_in_calc", {16'd0, difference}, 32'h1200);
      check("busy_in_calc", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rstc_busy", {31'd0, busy}, 32'd0);
      check("rstc_done", {31'd0, done}, 32'd0);
      check("rstc_diff", {16'd0, difference}, 32'd0);
      check("rstc_bout", {31'd0, borrow_out}, 32'd0);
      check("rstc_ovf", {31'd0, overflow}, 32'd0);
      repeat (8) @(posedge clk);
      #1;
      run_op(16'h00F0, 16'h000F, 1'b0);

      // Back-to-back start held in the DONE cycle.
      launch(16'h8000, 16'h0001, 1'b0);
      for (int i = 0; i < 20 && !done; i++)
         @(negedge clk);
      if (!done) check("b2b_wait", 32'd0, 32'd1);
      a = 16'h0005;
      b = 16'h0003;
      borrow_in = 1'b0;
      start = 1'b1;
      q.push_back(model(16'h0005, 16'h0003, 1'b0, cyc + 5));
      @(posedge clk);
      #1;
      start = 1'b0;
      a = 16'hAAAA;
      b = 16'h5555;
      @(posedge clk);
      #1;
      check("b2b_hold", {16'd0, difference}, 32'h7FFF);
      check("b2b_busy", {31'd0, busy}, 32'd1);
      drain();

      for (int n = 0; n < 2000; n++)
         run_op(16'($urandom), 16'($urandom), 1'($urandom));

      repeat (8) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
